// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle fetch/decode/execute control unit with PC, IR and retire counter.
module core_sequencer #(
   parameter int              PC_W     = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              CNT_W    = 16,
   parameter logic [3:0]      OP_LDR   = 4'hA,
   parameter logic [3:0]      OP_STR   = 4'hB,
   parameter logic [3:0]      OP_BR    = 4'hC,
   parameter logic [3:0]      OP_HALT  = 4'hF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [31:0]      instr_rdata,
   input  logic             mem_ready,
   input  logic [3:0]       flags_in,
   output logic [PC_W-1:0]  pc,
   output logic [31:0]      ir,
   output logic             fetch_req,
   output logic             mem_req,
   output logic             mem_we,
   output logic             sel_add_bus,
   output logic             sel_ldr_bus,
   output logic             reg_we,
   output logic             flags_we,
   output logic             cond_pass,
   output logic             halted,
   output logic [CNT_W-1:0] instr_count
);
   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
   state_t state, state_nx;
   logic [3:0] op;
   logic n, z, c, v, retire, count_en;
   logic [15:0] cond_tbl;
   logic [PC_W-1:0] imm_ext;
   assign op = ir[27:24];
   assign {n, z, c, v} = flags_in;
   // bit k holds the outcome of condition code k
   assign cond_tbl = {1'b0, 1'b1, z | (n ^ v), !z & !(n ^ v), n ^ v, !(n ^ v), !c | z, c & !z,
                      !v, v, !n, n, !c, c, !z, z};
   assign cond_pass = cond_tbl[ir[31:28]];
   assign imm_ext = PC_W'({{16{ir[18]}}, ir[18:3]});
   always_comb begin
      state_nx = state;
      fetch_req = 1'b0;
      mem_req = 1'b0;
      mem_we = 1'b0;
      sel_add_bus = 1'b0;
      sel_ldr_bus = 1'b0;
      reg_we = 1'b0;
      flags_we = 1'b0;
      halted = 1'b0;
      retire = 1'b0;
      case (state)
         IDLE: state_nx = run ? FETCH : IDLE;
         FETCH: begin
            fetch_req = 1'b1;
            if (mem_ready) state_nx = DECODE;
         end
         DECODE:
            if (!cond_pass || op == OP_BR) retire = 1'b1;
            else if (op == OP_HALT) state_nx = HALT;
            else if (op == OP_LDR || op == OP_STR) state_nx = MEM;
            else state_nx = EXEC;
         EXEC: begin
            reg_we = 1'b1;
            flags_we = ir[23];
            retire = 1'b1;
         end
         MEM: begin
            mem_req = 1'b1;
            sel_add_bus = 1'b1;
            mem_we = op == OP_STR;
            if (mem_ready) begin
               if (op == OP_STR) retire = 1'b1;
               else state_nx = WB;
            end
         end
         WB: begin
            reg_we = 1'b1;
            sel_ldr_bus = 1'b1;
            retire = 1'b1;
         end
         HALT: halted = 1'b1;
         default: state_nx = IDLE;
      endcase
      if (retire) state_nx = run ? FETCH : IDLE;
      count_en = retire || (state == DECODE && state_nx == HALT);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         pc <= RESET_PC;
         ir <= '0;
         instr_count <= '0;
      end else begin
         state <= state_nx;
         if (state == FETCH && mem_ready) begin
            ir <= instr_rdata;
            pc <= pc + PC_W'(1);
         end
         if (state == DECODE && cond_pass && op == OP_BR) pc <= pc + imm_ext;
         if (count_en && instr_count != '1) instr_count <= instr_count + CNT_W'(1);
      end
endmodule
